fifo_packer: RTL and testbench

- Downstream consumer of the `fifo` block. It pops DATA_WIDTH-bit entries through the fifo's deq/empty_n interface and packs PACK_RATIO consecutive entries into one wide word.
- The wide word is presented on a valid/ready output port.
- It sits between the narrow fifo and any wide-datapath sink, and supports flushing a partial word and a synchronous clear.

---
 rtl/fifo_packer.sv | 111 +++++++++++
 tb/tb_fifo_packer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_packer.sv
// fifo_packer: pops narrow entries from an upstream fifo and packs PACK_RATIO
// consecutive entries (little-endian) into one wide word on a valid/ready port.
// Supports flushing a partially filled word and a synchronous clear.
module fifo_packer #(
  parameter int DATA_WIDTH = 4,
  parameter int PACK_RATIO = 4,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             flush,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_empty_n,
  output logic                             in_deq,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [CNT_WIDTH:0]               out_beats,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int ACC_W = (PACK_RATIO - 1) * DATA_WIDTH;
  localparam int OUT_W = DATA_WIDTH * PACK_RATIO;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(PACK_RATIO - 1);

  logic [ACC_W-1:0]     acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 flush_pend_q;
  logic [OUT_W-1:0]     out_data_q;
  logic [CNT_WIDTH:0]   out_beats_q;
  logic                 out_valid_q;

  logic                 slot_free;
  logic                 beat;
  logic                 last_beat;
  logic                 flush_req;
  logic [OUT_W-1:0]     pack_word;

  // Output slot can take a new word if empty or being drained this edge.
  assign slot_free = !out_valid_q || out_ready;
  // Non-final beats always flow; the final beat waits for a free slot.
  assign in_deq    = in_empty_n && !clr && !rst && ((cnt_q < LAST) || slot_free);
  assign beat      = in_deq;
  assign last_beat = beat && (cnt_q == LAST);
  assign flush_req = flush || flush_pend_q;

  // Candidate output word: held entries below cnt, the incoming entry at cnt
  // when a beat happens, zeros above. Masking matters because acc keeps stale
  // entries from earlier words above the current fill level.
  genvar gi;
  generate
    for (gi = 0; gi < PACK_RATIO; gi++) begin : g_slot
      localparam logic [CNT_WIDTH-1:0] K = CNT_WIDTH'(gi);
      if (gi < PACK_RATIO - 1) begin : g_acc
        assign pack_word[gi*DATA_WIDTH +: DATA_WIDTH] =
          (K < cnt_q)             ? acc_q[gi*DATA_WIDTH +: DATA_WIDTH] :
          ((K == cnt_q) && beat)  ? in_data : '0;
      end else begin : g_top
        assign pack_word[gi*DATA_WIDTH +: DATA_WIDTH] = last_beat ? in_data : '0;
      end
    end
  endgenerate

  // Beat accumulation, word emission (full or flushed) and output handshake.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_beats_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (beat) begin
        // slot_free is implied on the last beat by in_deq.
        if (last_beat || (flush_req && slot_free)) begin
          out_data_q   <= pack_word;
          out_beats_q  <= {1'b0, cnt_q} + 1'b1;
          out_valid_q  <= 1'b1;
          cnt_q        <= '0;
          flush_pend_q <= 1'b0;
        end else begin
          acc_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
          cnt_q <= cnt_q + 1'b1;
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
        end
      end else if (flush_req && (cnt_q != '0)) begin
        // Flush of a partial word; an empty word is never produced.
        if (slot_free) begin
          out_data_q   <= pack_word;
          out_beats_q  <= {1'b0, cnt_q};
          out_valid_q  <= 1'b1;
          cnt_q        <= '0;
          flush_pend_q <= 1'b0;
        end else begin
          flush_pend_q <= 1'b1;
        end
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_packer.sv
// Directed testbench for fifo_packer with a small upstream fifo model.
module tb_fifo_packer;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        flush;
  logic [3:0]  in_data;
  logic        in_empty_n;
  logic        in_deq;
  logic [15:0] out_data;
  logic [2:0]  out_beats;
  logic        out_valid;
  logic        out_ready;

  int n_checks;
  int n_pass;

  // Upstream fifo model: entries pushed by the stimulus, popped on in_deq edges.
  logic [3:0] mem [0:63];
  logic [5:0] head;
  logic [5:0] tail;

  assign in_data    = mem[head];
  assign in_empty_n = (head != tail);

  fifo_packer #(.DATA_WIDTH(4), .PACK_RATIO(4), .CNT_WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .flush      (flush),
    .in_data    (in_data),
    .in_empty_n (in_empty_n),
    .in_deq     (in_deq),
    .out_data   (out_data),
    .out_beats  (out_beats),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the model fifo on each beat.
  always @(posedge clk) begin
    if (in_deq) head <= head + 6'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-22s got %h exp %h ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] v);
    mem[tail] = v;
    tail = tail + 6'd1;
  endtask

  // Advance one clock; leave time 1 after the edge for driving and checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    head      = '0;
    tail      = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst       = 1'b1;
    clr       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset: in_deq held low even with data available.
    push(4'hC);
    tick();
    tick();
    #1;
    check("rst_in_deq", 32'(in_deq), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_beats", 32'(out_beats), 32'd0);

    // Basic packing: C,A,5,3 -> 35AC.
    push(4'hA); push(4'h5); push(4'h3);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_deq%0d", i), 32'(in_deq), 32'd1);
      tick();
    end
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_data", 32'(out_data), 32'h35AC);
    check("basic_beats", 32'(out_beats), 32'd4);
    tick();
    check("basic_valid_drop", 32'(out_valid), 32'd0);

    // Backpressure: 1..8 with sink stalled.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(4'(i));
    for (int i = 0; i < 7; i++) tick();
    #1;
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_data", 32'(out_data), 32'h4321);
    check("bp_blocked_deq", 32'(in_deq), 32'd0);
    check("bp_fifo_nonempty", 32'(in_empty_n), 32'd1);
    tick();
    check("bp_still_held", 32'(out_data), 32'h4321);
    out_ready = 1'b1;
    #1;
    check("bp_release_deq", 32'(in_deq), 32'd1);
    tick();
    out_ready = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_data", 32'(out_data), 32'h8765);
    check("bp_next_beats", 32'(out_beats), 32'd4);
    out_ready = 1'b1;
    tick();
    check("bp_drain", 32'(out_valid), 32'd0);

    // Partial flush with the fifo empty.
    push(4'hC); push(4'hA);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    begin
      int waited;
      waited = 0;
      while (!out_valid && waited < 3) begin
        tick();
        waited++;
      end
    end
    check("flush_valid", 32'(out_valid), 32'd1);
    check("flush_data", 32'(out_data), 32'h00AC);
    check("flush_beats", 32'(out_beats), 32'd2);
    tick();
    check("flush_drain", 32'(out_valid), 32'd0);

    // Idle flush: nothing held, no word.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("idle_flush_v1", 32'(out_valid), 32'd0);
    tick();
    check("idle_flush_v2", 32'(out_valid), 32'd0);

    // Flush coincident with the third beat.
    push(4'hC); push(4'hA); push(4'h5);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flushbeat_valid", 32'(out_valid), 32'd1);
    check("flushbeat_data", 32'(out_data), 32'h05AC);
    check("flushbeat_beats", 32'(out_beats), 32'd3);
    tick();

    // clr mid-word discards C,A.
    push(4'hC); push(4'hA);
    tick(); tick();
    clr = 1'b1;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    #1;
    check("clr_in_deq", 32'(in_deq), 32'd0);
    tick();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("clr_valid", 32'(out_valid), 32'd1);
    check("clr_data", 32'(out_data), 32'h4321);
    check("clr_beats", 32'(out_beats), 32'd4);
    tick();

    // rst mid-word with an unaccepted word held: both are dropped.
    out_ready = 1'b0;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    push(4'hC); push(4'hA);
    for (int i = 0; i < 6; i++) tick();
    check("rst_held_data", 32'(out_data), 32'h4321);
    rst = 1'b1;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    #1;
    check("rst_mid_in_deq", 32'(in_deq), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_data", 32'(out_data), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check("rst_after_valid", 32'(out_valid), 32'd1);
    check("rst_after_data", 32'(out_data), 32'h4321);
    check("rst_after_beats", 32'(out_beats), 32'd4);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
